// File: rtl/data_sram_pkg.sv
// rtl/data_sram_pkg.sv - shared types and constants for the data SRAM controller
package data_sram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [3:0] SEL_WORD = 4'hF;
  localparam logic [3:0] SEL_HI   = 4'hC;
  localparam logic [3:0] SEL_LO   = 4'h3;

  localparam int WAIT_CYCLES_MAX = 15;

  function automatic logic misaligned(input logic [3:0] sel, input logic [1:0] lsb);
    return ((sel == SEL_WORD) && (lsb != 2'b00)) ||
           (((sel == SEL_HI) || (sel == SEL_LO)) && lsb[0]);
  endfunction

endpackage

// File: rtl/data_sram_wait_cnt.sv
// rtl/data_sram_wait_cnt.sv - loadable wait-state down-counter with zero flag
module data_sram_wait_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/data_sram_ctrl.sv
// rtl/data_sram_ctrl.sv - MEM-stage RAM port to wait-stated synchronous SRAM bridge
// Optional misaligned-access trap: DATA_SRAM_MISALIGN_CHK_EN
module data_sram_ctrl
  import data_sram_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cpu_ce,
  input  logic               cpu_we,
  input  logic [3:0]         cpu_sel,
  input  logic [31:0]        cpu_addr,
  input  logic [31:0]        cpu_wdata,
  output logic [31:0]        cpu_rdata,
  output logic               stallreq,
  output logic               bus_err,
  output logic               sram_ce_n,
  output logic               sram_we_n,
  output logic [3:0]         sram_be_n,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_dq_o,
  output logic               sram_dq_oe,
  input  logic [31:0]        sram_dq_i
);

  state_e               state_q, state_d;
  logic                 we_q, we_d;
  logic [3:0]           sel_q, sel_d;
  logic [SRAM_AW-1:0]   addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 ce_n_q, ce_n_d, we_n_q, we_n_d, oe_q, oe_d;
  logic [3:0]           be_n_q, be_n_d;
  logic [SRAM_AW-1:0]   saddr_q, saddr_d;
  logic [31:0]          dq_q, dq_d;
  logic                 cnt_load, cnt_dec, cnt_zero, illegal;
  logic                 unused_addr;

  assign unused_addr = ^{cpu_addr[31:SRAM_AW+2], cpu_addr[1:0]};

`ifdef DATA_SRAM_MISALIGN_CHK_EN
  assign illegal = misaligned(cpu_sel, cpu_addr[1:0]);
`else
  assign illegal = 1'b0;
`endif

  data_sram_wait_cnt #(.W(4)) u_wait_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (4'(WAIT_CYCLES)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_ce) begin
          we_d     = cpu_we;
          sel_d    = cpu_sel;
          addr_d   = cpu_addr[SRAM_AW+1:2];
          wdata_d  = cpu_wdata;
          cnt_load = 1'b1;
          if (illegal) begin
            state_d = DONE;
            rdata_d = '0;
            err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (cnt_zero) begin
          if (!we_q) rdata_d = sram_dq_i;
          state_d = DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // SRAM pins are registered, so they follow the state being entered
    ce_n_d  = 1'b1;
    we_n_d  = 1'b1;
    be_n_d  = 4'hF;
    saddr_d = '0;
    dq_d    = '0;
    oe_d    = 1'b0;
    if (state_d == ACCESS) begin
      ce_n_d  = 1'b0;
      saddr_d = addr_d;
      be_n_d  = ~sel_d;
      if (we_d) begin
        we_n_d = 1'b0;
        dq_d   = wdata_d;
        oe_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      ce_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      be_n_q  <= 4'hF;
      saddr_q <= '0;
      dq_q    <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ce_n_q  <= ce_n_d;
      we_n_q  <= we_n_d;
      be_n_q  <= be_n_d;
      saddr_q <= saddr_d;
      dq_q    <= dq_d;
      oe_q    <= oe_d;
    end
  end

  assign stallreq   = reset_n && (((state_q == IDLE) && cpu_ce) || (state_q == ACCESS));
  assign cpu_rdata  = rdata_q;
  assign bus_err    = err_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_be_n  = be_n_q;
  assign sram_addr  = saddr_q;
  assign sram_dq_o  = dq_q;
  assign sram_dq_oe = oe_q;

endmodule

// File: tb/tb_data_sram_ctrl.sv
// tb/tb_data_sram_ctrl.sv - scoreboard bench: WAIT_CYCLES=1 instance plus WAIT_CYCLES=0 back-to-back instance
module tb_data_sram_ctrl;

  localparam bit CHK = `ifdef DATA_SRAM_MISALIGN_CHK_EN 1'b1 `else 1'b0 `endif;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic        a_ce, a_we, a_stall, a_err, a_ce_n, a_we_n, a_oe;
  logic [3:0]  a_sel, a_be_n;
  logic [31:0] a_addr, a_wdata, a_rdata, a_dq_o, a_dq_i;
  logic [17:0] a_saddr;
  logic        b_ce, b_we, b_stall, b_err, b_ce_n, b_we_n, b_oe;
  logic [3:0]  b_sel, b_be_n;
  logic [31:0] b_addr, b_wdata, b_rdata, b_dq_o, b_dq_i;
  logic [17:0] b_saddr;

  data_sram_ctrl #(.WAIT_CYCLES(1), .SRAM_AW(18)) dut_a (
    .clk(clk), .reset_n(reset_n), .cpu_ce(a_ce), .cpu_we(a_we), .cpu_sel(a_sel),
    .cpu_addr(a_addr), .cpu_wdata(a_wdata), .cpu_rdata(a_rdata), .stallreq(a_stall),
    .bus_err(a_err), .sram_ce_n(a_ce_n), .sram_we_n(a_we_n), .sram_be_n(a_be_n),
    .sram_addr(a_saddr), .sram_dq_o(a_dq_o), .sram_dq_oe(a_oe), .sram_dq_i(a_dq_i));

  data_sram_ctrl #(.WAIT_CYCLES(0), .SRAM_AW(18)) dut_b (
    .clk(clk), .reset_n(reset_n), .cpu_ce(b_ce), .cpu_we(b_we), .cpu_sel(b_sel),
    .cpu_addr(b_addr), .cpu_wdata(b_wdata), .cpu_rdata(b_rdata), .stallreq(b_stall),
    .bus_err(b_err), .sram_ce_n(b_ce_n), .sram_we_n(b_we_n), .sram_be_n(b_be_n),
    .sram_addr(b_saddr), .sram_dq_o(b_dq_o), .sram_dq_oe(b_oe), .sram_dq_i(b_dq_i));

  // external SRAM models, cleared while reset is held
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  assign a_dq_i = mem_a[a_saddr[7:0]];
  assign b_dq_i = mem_b[b_saddr[7:0]];

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) begin
        mem_a[i] <= 32'h0;
        mem_b[i] <= 32'h0;
      end
      mem_b[0] <= 32'h1111_1111;
      mem_b[1] <= 32'h2222_2222;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!a_ce_n && !a_we_n && a_oe && !a_be_n[i]) mem_a[a_saddr[7:0]][8*i +: 8] <= a_dq_o[8*i +: 8];
        if (!b_ce_n && !b_we_n && b_oe && !b_be_n[i]) mem_b[b_saddr[7:0]][8*i +: 8] <= b_dq_o[8*i +: 8];
      end
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          stall;
    int          ce;
    int          we;
    logic [17:0] addr;
    logic [3:0]  be_n;
    logic [31:0] wd;
  } exp_t;

  exp_t        sb_a[$];
  logic [31:0] sb_b[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor A: accumulate per-transaction strobe activity, compare at DONE
  int          m_st, m_ce, m_we;
  logic [17:0] m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_wd;
  exp_t        e;

  always @(negedge clk) begin
    if (!reset_n) begin
      m_st = 0; m_ce = 0; m_we = 0;
    end else begin
      if (a_stall) m_st++;
      if (!a_ce_n) begin m_ce++; m_addr = a_saddr; m_be = a_be_n; end
      if (!a_we_n) begin m_we++; m_wd = a_dq_o; end
      if (a_ce && !a_stall) begin
        if (sb_a.size() == 0) begin
          chk("sb_a_underflow", 64'd1, 64'd0);
        end else begin
          e = sb_a.pop_front();
          chk("rdata", a_rdata, e.rdata);
          chk("bus_err", a_err, e.err);
          chk("stall_cycles", m_st, e.stall);
          chk("ce_cycles", m_ce, e.ce);
          chk("we_cycles", m_we, e.we);
          if (e.ce > 0) begin
            chk("sram_addr", m_addr, e.addr);
            chk("sram_be_n", m_be, e.be_n);
          end
          if (e.we > 0) chk("sram_dq_o", m_wd, e.wd);
        end
        m_st = 0; m_ce = 0; m_we = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && b_ce && !b_stall) begin
      if (sb_b.size() == 0) begin
        chk("sb_b_underflow", 64'd1, 64'd0);
      end else begin
        chk("b_rdata", b_rdata, sb_b.pop_front());
        chk("b_bus_err", b_err, 64'd0);
      end
    end
  end

  task automatic reset_chk();
    chk("rst_ctrl", {a_stall, a_err, a_ce_n, a_we_n, a_be_n, a_oe}, {1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 1'b0});
    chk("rst_rdata", a_rdata, 64'd0);
    chk("rst_addr_dq", {a_saddr, a_dq_o}, 64'd0);
  endtask

  task automatic a_req(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err,
                       input logic [17:0] exp_addr, input logic corrupt);
    exp_t x;
    bit   done;
    @(posedge clk); #1;
    a_ce = 1'b1; a_we = we; a_sel = sel; a_addr = addr; a_wdata = wdata;
    x.rdata = exp_rd; x.err = exp_err; x.addr = exp_addr; x.be_n = ~sel; x.wd = wdata;
    x.stall = exp_err ? 1 : 3;
    x.ce    = exp_err ? 0 : 2;
    x.we    = (exp_err || !we) ? 0 : 2;
    sb_a.push_back(x);
    if (corrupt) begin
      @(posedge clk); #1;
      a_addr = ~addr; a_wdata = ~wdata; a_sel = ~sel; a_we = ~we;
    end
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!a_stall) done = 1'b1;
    end
    if (!done) chk("a_timeout", 64'd1, 64'd0);
  endtask

  logic [5:0] pat;
  int         nce;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    a_ce = 0; a_we = 0; a_sel = 0; a_addr = 0; a_wdata = 0;
    b_ce = 0; b_we = 0; b_sel = 4'hF; b_addr = 0; b_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_chk();
    @(posedge clk); #1;
    reset_n = 1'b1;

    // reset while a write is in ACCESS
    @(posedge clk); #1;
    a_ce = 1; a_we = 1; a_sel = 4'hF; a_addr = 32'h200; a_wdata = 32'h5555_5555;
    @(posedge clk); #1;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      reset_chk();
    end
    @(posedge clk); #1;
    reset_n = 1'b1; a_ce = 0;
    @(posedge clk); #1;

    //   we    sel    addr          wdata         exp_rd        err   exp_addr  corrupt
    a_req(1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0,    18'h40,   0);
    a_req(0, 4'hF, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0,   18'h40,   0);
    a_req(1, 4'h2, 32'h0000_0101, 32'h0000_AA00, 32'hDEAD_BEEF, 0,   18'h40,   0);
    a_req(0, 4'hF, 32'h0000_0100, 32'h0,         32'hDEAD_AAEF, 0,   18'h40,   0);
    a_req(1, 4'hF, 32'h0100_0000, 32'h1234_5678, 32'hDEAD_AAEF, 0,   18'h0,    0);
    a_req(0, 4'hF, 32'h0000_0000, 32'h0,         32'h1234_5678, 0,   18'h0,    0);
    a_req(1, 4'h0, 32'h0000_0104, 32'hFFFF_FFFF, 32'h1234_5678, 0,   18'h41,   0);
    a_req(0, 4'h0, 32'h0000_0104, 32'h0,         32'h0,         0,   18'h41,   0);
    a_req(1, 4'hF, 32'h0000_0108, 32'hCAFE_F00D, 32'h0,         0,   18'h42,   1);
    a_req(0, 4'hF, 32'h0000_0108, 32'h0,         32'hCAFE_F00D, 0,   18'h42,   0);
    a_req(0, 4'hF, 32'h0000_0102, 32'h0,         CHK ? 32'h0 : 32'hDEAD_AAEF, CHK, 18'h40, 0);
    a_req(0, 4'hC, 32'h0000_0101, 32'h0,         CHK ? 32'h0 : 32'hDEAD_AAEF, CHK, 18'h40, 0);
    a_req(0, 4'h3, 32'h0000_0102, 32'h0,         32'hDEAD_AAEF, 0,   18'h40,   0);
    @(posedge clk); #1;
    a_ce = 0;

    // WAIT_CYCLES=0 back-to-back reads of words 0 and 1
    @(posedge clk); #1;
    b_ce = 1; b_addr = 32'h0;
    sb_b.push_back(32'h1111_1111);
    pat = '0; nce = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat = {pat[4:0], b_stall};
      if (!b_ce_n) nce++;
      if (i == 2) begin
        @(posedge clk); #1;
        b_addr = 32'h4;
        sb_b.push_back(32'h2222_2222);
      end
    end
    @(posedge clk); #1;
    b_ce = 0;
    chk("b_stall_pattern", pat, 6'b110110);
    chk("b_access_cycles", nce, 64'd2);

    repeat (3) @(posedge clk);
    chk("sb_a_drained", sb_a.size(), 64'd0);
    chk("sb_b_drained", sb_b.size(), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_sram_ctrl.md
Name: data_sram_ctrl

Overview:
- Downstream data-memory controller for the CPU core's MEM-stage RAM port (ram_ce/we/sel/addr/data).
- Converts each single-cycle CPU request into a multi-cycle access to an external synchronous word-wide SRAM with configurable wait states.
- Holds the pipeline by raising stallreq to ctrl until the access completes, then returns read data on ram_data_i.

Parameters:
- WAIT_CYCLES, 1, extra SRAM cycles per access (0..15); the access phase lasts WAIT_CYCLES+1 cycles.
- SRAM_AW, 18, SRAM word-address width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- cpu_ce  in  1  request valid (CPU ram_ce_o)
- cpu_we  in  1  1=write, 0=read
- cpu_sel  in  4  byte lane enables, bit3 = bits[31:24]
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  write data, already lane-aligned
- cpu_rdata  out  32  read data to CPU ram_data_i
- stallreq  out  1  pipeline stall request to ctrl
- bus_err  out  1  misaligned-access pulse (see Optional Feature)
- sram_ce_n  out  1  SRAM chip enable, active low
- sram_we_n  out  1  SRAM write enable, active low
- sram_be_n  out  4  SRAM byte enables, active low
- sram_addr  out  SRAM_AW  SRAM word address
- sram_dq_o  out  32  SRAM write data
- sram_dq_oe  out  1  SRAM data output enable
- sram_dq_i  in  32  SRAM read data, valid on the last access cycle

Behaviour:
- Reset value of every output, registered on the clk edge while reset_n=0: cpu_rdata=0, stallreq=0, bus_err=0, sram_ce_n=1, sram_we_n=1, sram_be_n=4'hF, sram_addr=0, sram_dq_o=0, sram_dq_oe=0. The FSM resets to IDLE and the counter to 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - On cpu_ce=1, register we, sel, addr[SRAM_AW+1:2] and wdata; load the counter with WAIT_CYCLES; go to ACCESS.
  - cpu_ce=0 stays in IDLE.
- ACCESS:
  - Drive sram_ce_n=0, sram_addr=captured word address, sram_be_n=~sel.
  - For a write, also drive sram_we_n=0, sram_dq_o=wdata, sram_dq_oe=1.
  - The counter decrements each cycle. At count 0, a read latches sram_dq_i into cpu_rdata, then the FSM goes to DONE.
- DONE:
  - SRAM controls return to idle values.
  - cpu_rdata holds the read word; it holds its previous value after a write.
  - Always returns to IDLE. No new request is accepted in DONE, because the CPU still presents the same request during this cycle.
- stallreq is combinational: (state==IDLE && cpu_ce) || state==ACCESS. It is low in DONE, so the pipeline advances at the end of DONE.
- Latency: the request is seen in cycle N; cpu_rdata is valid in DONE at N+WAIT_CYCLES+2. Back-to-back requests cost WAIT_CYCLES+3 cycles each.
- Address bits above SRAM_AW+1 are ignored (address wraps). cpu_addr[1:0] is not used for lane selection; cpu_sel governs.
- cpu_sel=0: the full cycle still runs with sram_be_n=4'hF, so no bytes are written. A read returns the SRAM word.
- Changes on cpu_* inputs after capture are ignored until IDLE.
- Reset asserted mid-ACCESS: the FSM aborts to IDLE next edge and all SRAM strobes deassert. A partial write is permitted.

Optional Feature:
- Macro: DATA_SRAM_MISALIGN_CHK_EN.
- With the macro defined, a request in IDLE is illegal when:
  - cpu_sel=4'hF and addr[1:0]!=0, or
  - cpu_sel is 4'h3 or 4'hC and addr[0]!=0.
- An illegal request skips ACCESS and goes straight to DONE. No SRAM strobe asserts, cpu_rdata=0, and bus_err=1 for exactly the DONE cycle. stallreq is high only in the capture cycle.
- Without the macro, bus_err is tied to 0 and no check is made.

Decomposition:
- Shared package data_sram_pkg holds:
  - the state enum (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2);
  - sel constants SEL_WORD=4'hF, SEL_HI=4'hC, SEL_LO=4'h3;
  - the WAIT_CYCLES maximum constant (15).
- The FSM, counter and datapath are compact, so no sub-module is required. Optionally factor out data_sram_wait_cnt, a loadable down-counter with a zero flag.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles mid-ACCESS -> all outputs at reset values, FSM IDLE, SRAM strobes deasserted next edge.
- Word write then read, WAIT_CYCLES=1: write addr 0x100, data 0xDEADBEEF, sel F.
  - Expect sram_we_n=0 for 2 cycles, sram_addr=0x40, stallreq high 3 cycles.
  - Read of the same address returns 0xDEADBEEF in DONE, 3 cycles after the request.
- Byte write: sel=4'h2, addr 0x101, wdata 0x0000AA00 -> sram_be_n=4'hD; a read of 0x100 returns 0xDEADAAEF.
- WAIT_CYCLES=0 back-to-back reads of 0x0 and 0x4 -> ACCESS lasts 1 cycle each; stallreq pattern 1,1,0,1,1,0; cpu_rdata updates in each DONE.
- Address wrap, SRAM_AW=18: write at 0x0100_0000 -> sram_addr=0 (upper bits ignored).
- Misaligned access, with DATA_SRAM_MISALIGN_CHK_EN: word read at 0x102 -> no sram_ce_n assertion, bus_err=1 for one cycle, cpu_rdata=0. Without the macro, the same stimulus performs a normal read of word 0x40.
